// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a CPU memory stage: IDLE/WAIT/RESP handshake over a word array.
// Optional misalignment error checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [2**DEPTH_LOG2];

  logic                  accept, go_resp;
  logic                  op_we, op_err, bad_range, bad_align;
  logic [31:0]           op_addr, op_wdata;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic                  unused_low_bits;

  // With LATENCY=1 the acceptance edge is also the RESP-entry edge, so the
  // operation is taken straight from the inputs instead of the latched copy.
  always_comb begin
    accept   = req_i && (state != WAIT);
    go_resp  = (state == WAIT) ? (cnt == '0) : (accept && (LATENCY == 1));
    op_we    = (state == WAIT) ? lat_we    : we_i;
    op_addr  = (state == WAIT) ? lat_addr  : addr_i;
    op_wdata = (state == WAIT) ? lat_wdata : wdata_i;
    op_idx   = op_addr[DEPTH_LOG2+1:2];
    bad_range = |op_addr[31:DEPTH_LOG2+2];
`ifdef DMEM_ALIGN_CHECK_EN
    bad_align = |op_addr[1:0];
`else
    bad_align = 1'b0;
`endif
    op_err = bad_range | bad_align;
  end

  assign unused_low_bits = &{1'b0, op_addr[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
        else        state_nxt = IDLE;
      end
      WAIT:    if (cnt == '0) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= we_i;
        lat_addr  <= addr_i;
        lat_wdata <= wdata_i;
        if (LATENCY > 1) cnt <= CNT_LOAD;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      err_o <= go_resp && op_err;
      // Successful stores leave the last load data in place; errors read as zero.
      if (go_resp && (op_err || !op_we))
        rdata_o <= op_err ? '0 : mem[op_idx];
    end
  end

  // Array is deliberately not reset; the rst_i gate covers a request seen while reset is high.
  always_ff @(posedge clk_i) begin
    if (go_resp && op_we && !op_err && !rst_i)
      mem[op_idx] <= op_wdata;
  end

  assign busy_o = (state == WAIT);
  assign ack_o  = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: a LATENCY=4 and a LATENCY=1 responder driven by directed and random requests,
// compared against a per-instance word-array model built from the access rules.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        ack_a, busy_a, err_a, ack_b, busy_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] mm      [2][256];
  bit          written [2][256];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a), .err_o(err_a));

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b), .err_o(err_b));

  function automatic bit align_en();
`ifdef DMEM_ALIGN_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("idle_ack_a", ack_a, 1'b0);
      chk1("idle_ack_b", ack_b, 1'b0);
      chk1("idle_busy_a", busy_a, 1'b0);
    end
  endtask

  // Issue one request and follow it to its ack; returns at the falling edge of the ack cycle.
  task automatic txn(input int sel, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    int          lat;
    bit          e;
    int          idx;
    logic [31:0] exp_rd;
    lat = (sel != 0) ? 1 : 4;
    idx = int'(addr[9:2]);
    e   = (addr[31:10] != 0) || (align_en() && addr[1:0] != 2'b00);
    exp_rd = e ? 32'h0 : (we ? last_rd[sel] : mm[sel][idx]);
    if (sel != 0) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else          begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    if (sel != 0) begin we_b = 1'($urandom); addr_b = $urandom; wdata_b = $urandom; end
    else          begin we_a = 1'($urandom); addr_a = $urandom; wdata_a = $urandom; end
    if (we && !e) begin mm[sel][idx] = wd; written[sel][idx] = 1'b1; end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk1("ack", (sel != 0) ? ack_b : ack_a, k == lat);
      chk1("busy", (sel != 0) ? busy_b : busy_a, k < lat);
      if (k == lat) begin
        chk1("err", (sel != 0) ? err_b : err_a, e);
        chk32("rdata", (sel != 0) ? rdata_b : rdata_a, exp_rd);
      end
    end
    last_rd[sel] = exp_rd;
  endtask

  initial begin
    int          sel, word, kind;
    bit          we;
    logic [31:0] addr;

    rst = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);
    chk1("rst_ack_a", ack_a, 1'b0);
    chk1("rst_busy_a", busy_a, 1'b0);
    chk1("rst_err_a", err_a, 1'b0);
    chk32("rst_rdata_a", rdata_a, 32'h0);
    chk1("rst_ack_b", ack_b, 1'b0);
    chk32("rst_rdata_b", rdata_b, 32'h0);
    rst = 1'b0;
    idle(1);

    // Known contents, then store 0xDEADBEEF to 0x10 with a same-word load accepted in its ack cycle.
    txn(0, 1, 32'h0000_0000, 32'hA5A5_0000);
    idle(1);
    txn(0, 1, 32'h0000_0020, 32'h1234_5678);
    idle(2);
    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    txn(0, 0, 32'h0000_0010, 32'h0);
    idle(1);

    // Out of range store must not alias onto word 0.
    txn(0, 1, 32'h0000_0400, 32'hFFFF_FFFF);
    idle(1);
    txn(0, 0, 32'h0000_0000, 32'h0);
    idle(1);
    txn(0, 0, 32'h0000_0013, 32'h0);
    txn(0, 1, 32'h0000_0044, 32'h0BAD_F00D);
    idle(1);

    // Single-cycle latency instance: consecutive acks.
    txn(1, 1, 32'h0000_0000, 32'h1111_1111);
    txn(1, 1, 32'h0000_0004, 32'h2222_2222);
    txn(1, 1, 32'h0000_0008, 32'h3333_3333);
    idle(1);
    txn(1, 0, 32'h0000_0000, 32'h0);
    txn(1, 0, 32'h0000_0004, 32'h0);
    txn(1, 0, 32'h0000_0008, 32'h0);
    idle(1);

    // Reset while a store is waiting: no ack and no write.
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h0000_0020; wdata_a = 32'h0000_0055;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(negedge clk);
    chk1("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async_rst_busy", busy_a, 1'b0);
    chk1("async_rst_ack", ack_a, 1'b0);
    @(negedge clk);
    chk32("rst_rdata_a2", rdata_a, 32'h0);
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    idle(6);
    txn(0, 0, 32'h0000_0020, 32'h0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      sel  = int'($urandom_range(0, 1));
      we   = 1'($urandom);
      word = int'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 7));
      if (!we && !written[sel][word]) we = 1'b1;
      addr = {22'h0, word[7:0], 2'b00};
      if (kind == 0) addr = addr | (32'h400 << $urandom_range(0, 21));
      else if (kind == 1) addr[1:0] = 2'($urandom_range(1, 3));
      txn(sel, we, addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
